addkey_subbytes_seq: RTL and testbench

//  Upstream feeder for the gate-level SBOX netlist. Accepts a 128-bit block
//  and a 128-bit round key, and XORs them on capture (AddRoundKey).

---
 rtl/aes_pkg.sv | 20 ++
 rtl/addkey_subbytes_seq.sv | 97 +++++++++
 tb/tb_addkey_subbytes_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, block size and a byte-select
// helper used by the AddRoundKey/SubBytes sequencer.
package aes_pkg;

    localparam int AES_NBYTES = 16;
    localparam int AES_CNT_W  = $clog2(AES_NBYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    // Byte idx of a block; byte 0 sits in the least significant bits.
    function automatic logic [7:0] sel_byte(input logic [8*AES_NBYTES-1:0] v,
                                            input logic [AES_CNT_W-1:0]    idx);
        return v[8*idx +: 8];
    endfunction

endpackage

// File: rtl/addkey_subbytes_seq.sv
// AddRoundKey on capture, then SubBytes one byte per cycle through an
// external shared SBOX; the substituted block is offered with valid/ready.
module addkey_subbytes_seq
    import aes_pkg::*;
#(
    parameter int NBYTES = AES_NBYTES,
    parameter int CNT_W  = AES_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_data,
    input  logic [8*NBYTES-1:0] in_key,
    output logic [7:0]          sbox_in,
    input  logic [7:0]          sbox_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_data
);

    localparam int W = 8 * NBYTES;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       work_q, work_d;
    logic [W-1:0]       result_q, result_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d     = in_data ^ in_key;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                // SBOX is combinational: its answer for byte cnt lands this edge.
                result_d[8*cnt_q +: 8] = sbox_out;
                cnt_d                  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NBYTES - 1)) begin
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                cnt_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Park the SBOX input at zero when idle to avoid needless toggling.
    assign sbox_in   = (state_q == S_RUN) ? sel_byte(work_q, cnt_q) : 8'h00;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = result_q;

endmodule

// File: tb/tb_addkey_subbytes_seq.sv
// Directed bench: the sequencer wired to a behavioural AES SBOX table.
module tb_addkey_subbytes_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic [7:0]   sbox_in;
    logic [7:0]   sbox_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    assign sbox_out = SBOX[sbox_in];

    addkey_subbytes_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    localparam logic [127:0] INC = 128'h0F0E0D0C0B0A09080706050403020100;

    // Present one block for a single cycle, then scribble the inputs.
    task automatic send(input logic [127:0] d, input logic [127:0] k);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {4{32'hDEADBEEF}};
        in_key   = {4{32'h5A5AA5A5}};
    endtask

    // Counts negedges until out_valid, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0 || sbox_in !== 8'h00) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h sbox_in=%h want 1 0 0 00",
                     in_ready, out_valid, out_data, sbox_in);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        int n;
        send(128'h0, 128'h0);
        wait_valid(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL zero_latency: got %0d want 16", n);
        end
        checks++;
        if (out_data !== {16{8'h63}}) begin
            errors++;
            $display("FAIL zero_data: got %h want %h", out_data, {16{8'h63}});
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_key_xor();
        int n;
        send(128'h01, 128'h80);
        wait_valid(n);
        checks++;
        if (out_data !== {{15{8'h63}}, 8'h0C}) begin
            errors++;
            $display("FAIL key_xor: got %h want %h", out_data, {{15{8'h63}}, 8'h0C});
        end
        release_out();
    endtask

    task automatic test_sbox_seq();
        int bad = 0;
        int n;
        send(INC, 128'h0);
        for (int i = 0; i < 16; i++) begin
            if (sbox_in !== 8'(i)) begin
                bad++;
                $display("FAIL sbox_seq[%0d]: got %h want %h", i, sbox_in, 8'(i));
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) errors++;
        wait_valid(n);
        checks++;
        if (out_valid !== 1'b1 || out_data[7:0] !== 8'h63 || out_data[15:8] !== 8'h7C) begin
            errors++;
            $display("FAIL sbox_seq_out: valid=%b b0=%h b1=%h want 1 63 7c",
                     out_valid, out_data[7:0], out_data[15:8]);
        end
        checks++;
        if (sbox_in !== 8'h00) begin
            errors++;
            $display("FAIL sbox_idle: got %h want 00", sbox_in);
        end
        release_out();
    endtask

    task automatic test_hold();
        int n;
        int bad = 0;
        send(128'h0, 128'h0);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            in_data  = {16{8'hFF}};
            in_key   = 128'h0;
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== {16{8'h63}} || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d]: valid=%b data=%h in_ready=%b want 1 %h 0",
                         i, out_valid, out_data, in_ready, {16{8'h63}});
            end
        end
        checks++;
        if (bad != 0) errors++;
        in_valid = 1'b0;
        release_out();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sbox_in !== 8'h00) begin
            errors++;
            $display("FAIL hold_ignore: valid=%b in_ready=%b sbox_in=%h want 0 1 00",
                     out_valid, in_ready, sbox_in);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        send(INC, 128'h0);
        repeat (7) @(negedge clk);
        checks++;
        if (sbox_in !== 8'h07) begin
            errors++;
            $display("FAIL mid_cnt7: sbox_in=%h want 07", sbox_in);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sbox_in !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b sbox_in=%h want 1 0 00",
                     in_ready, out_valid, sbox_in);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_valid(n);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_valid: out_valid=%b want 0", out_valid);
        end
        send({16{8'h01}}, 128'h0);
        wait_valid(n);
        checks++;
        if (n !== 16 || out_data !== {16{8'h7C}}) begin
            errors++;
            $display("FAIL mid_next: lat=%0d data=%h want 16 %h", n, out_data, {16{8'h7C}});
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 128'h0;
        in_key    = 128'h0;
        out_ready = 1'b1;
        @(negedge clk);
        in_data = 128'h0;
        in_key  = {16{8'h01}};
        wait_valid(n);
        checks++;
        if (n !== 16 || out_data !== {16{8'h63}}) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d data=%h want 16 %h", n, out_data, {16{8'h63}});
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: in_ready=%b want 0", in_ready);
        end
        in_valid = 1'b0;
        wait_valid(n);
        checks++;
        if (n !== 16 || out_data !== {16{8'h7C}}) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d data=%h want 16 %h", n, out_data, {16{8'h7C}});
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_key_xor();
        test_sbox_seq();
        test_hold();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
